// File: rtl/rcs.sv
// rcs: G-bit ripple-borrow subtractor with a single registered output stage.
//   diff = (a - b - bin) mod 2^G, bout = final borrow of the chain.
//   The borrow ripples LSB->MSB through a generate chain of 1-bit
//   full-subtractor cells; no '-' operator is used in the datapath.
// Optional feature (macro RCS_OVF_EN): adds registered output ovf, the
//   signed overflow of a - b - bin, with the same latency/reset/hold rules.

// One full-subtractor cell: difference bit and borrow to the next stage.
module rcs_fs_cell (
   input  logic a_i,
   input  logic b_i,
   input  logic br_i,
   output logic d_o,
   output logic br_o
);

   logic axb_s;

   assign axb_s = a_i ^ b_i;
   assign d_o   = axb_s ^ br_i;
   // Borrow when a=0,b=1, or when a==b and a borrow arrives from below.
   assign br_o  = (~a_i & b_i) | (~axb_s & br_i);

endmodule

module rcs #(
   parameter int G = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [G-1:0] a,
   input  logic [G-1:0] b,
   input  logic         bin,
   output logic         out_valid,
   output logic [G-1:0] diff,
   output logic         bout
`ifdef RCS_OVF_EN
   ,
   output logic         ovf
`endif
);

   // Borrow chain: br_s[0] is the borrow-in, br_s[G] the borrow-out.
   logic [G:0]   br_s;
   logic [G-1:0] diff_s;

   // Output stage registers and their next-state values.
   logic [G-1:0] diff_q;
   logic [G-1:0] diff_d;
   logic         bout_q;
   logic         bout_d;
   logic         valid_q;
   logic         valid_d;

   assign br_s[0] = bin;

   genvar gi;
   generate
      for (gi = 0; gi < G; gi = gi + 1) begin : g_cell
         rcs_fs_cell u_cell (
            .a_i  (a[gi]),
            .b_i  (b[gi]),
            .br_i (br_s[gi]),
            .d_o  (diff_s[gi]),
            .br_o (br_s[gi+1])
         );
      end
   endgenerate

`ifdef RCS_OVF_EN
   logic ovf_s;
   logic ovf_q;
   logic ovf_d;

   // Signed overflow only possible when operand signs differ and the
   // result sign departs from the minuend's sign.
   assign ovf_s = (a[G-1] ^ b[G-1]) & (diff_s[G-1] ^ a[G-1]);

   // Next-state for the overflow flag: capture on in_valid, otherwise hold.
   always_comb begin
      ovf_d = ovf_q;
      if (in_valid) begin
         ovf_d = ovf_s;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Overflow register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

   // Next-state for result and valid: capture on in_valid; otherwise the
   // result holds (inputs are ignored, so X on them cannot leak in) and
   // out_valid drops.
   always_comb begin
      diff_d  = diff_q;
      bout_d  = bout_q;
      valid_d = 1'b0;
      if (in_valid) begin
         diff_d  = diff_s;
         bout_d  = br_s[G];
         valid_d = 1'b1;
      end else begin
         diff_d  = diff_q;
         bout_d  = bout_q;
         valid_d = 1'b0;
      end
   end

   // Output registers; reset overrides any operation presented this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         diff_q  <= {G{1'b0}};
         bout_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         valid_q <= valid_d;
      end
   end

   assign diff      = diff_q;
   assign bout      = bout_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_rcs.sv
// Self-checking bench for rcs (G=32). Directed tests use expected values
// written out as constants; the randomized stream is checked against an
// arithmetic reference model of a - b - bin. Build with +define+RCS_OVF_EN
// to also exercise the ovf output.
module tb_rcs;

   localparam int G = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [G-1:0] a;
   logic [G-1:0] b;
   logic         bin;
   logic         out_valid;
   logic [G-1:0] diff;
   logic         bout;
`ifdef RCS_OVF_EN
   logic         ovf;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state (what the registered outputs should show).
   logic [G-1:0] m_diff;
   logic         m_bout;
   logic         m_valid;
   logic         m_ovf;

   always #5 clk = ~clk;

   rcs #(.G(G)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .diff      (diff),
      .bout      (bout)
`ifdef RCS_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   // Full-precision unsigned a - b - bin; top bit is the borrow-out.
   function automatic logic [G:0] ref_sub(input logic [G-1:0] x, input logic [G-1:0] y,
                                          input logic c);
      return {1'b0, x} - {1'b0, y} - {{G{1'b0}}, c};
   endfunction

   // Signed overflow: exact signed result falls outside the 32-bit range.
   function automatic logic ref_ovf(input logic [G-1:0] x, input logic [G-1:0] y,
                                    input logic c);
      longint r;
      r = longint'($signed(x)) - longint'($signed(y)) - longint'({1'b0, c});
      return (r > 64'sd2147483647) || (r < -64'sd2147483648);
   endfunction

   // Drive one cycle of inputs, clock it, update the model, settle 1 time unit.
   task automatic cycle(input logic v, input logic [G-1:0] x, input logic [G-1:0] y,
                        input logic c, input logic r);
      logic [G:0] res;
      rst      = r;
      in_valid = v;
      a        = x;
      b        = y;
      bin      = c;
      @(posedge clk);
      if (r) begin
         m_diff  = '0;
         m_bout  = 1'b0;
         m_valid = 1'b0;
         m_ovf   = 1'b0;
      end else if (v) begin
         res     = ref_sub(x, y, c);
         m_diff  = res[G-1:0];
         m_bout  = res[G];
         m_valid = 1'b1;
         m_ovf   = ref_ovf(x, y, c);
      end else begin
         m_valid = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset;
      cycle(1'b1, 32'd12, 32'd7, 1'b1, 1'b1);
      checks++;
      if (diff !== 32'd0 || bout !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_cyc1: got diff=%h bout=%b vld=%b, want 0/0/0", diff, bout, out_valid);
      end
      cycle(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
      checks++;
      if (diff !== 32'd0 || bout !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_cyc2: got diff=%h bout=%b vld=%b, want 0/0/0", diff, bout, out_valid);
      end
      cycle(1'b0, 32'd0, 32'd5, 1'b1, 1'b0);
      checks++;
      if (diff !== 32'd0 || bout !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_after: got diff=%h bout=%b vld=%b, want 0/0/0", diff, bout, out_valid);
      end
   endtask

   task automatic test_basic;
      cycle(1'b1, 32'd12, 32'd7, 1'b1, 1'b0);
      checks++;
      if (diff !== 32'd4 || bout !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL basic_12_7_1: got diff=%h bout=%b vld=%b, want 4/0/1", diff, bout, out_valid);
      end
      // Idle with X inputs: valid drops, result holds.
      cycle(1'b0, 'x, 'x, 1'bx, 1'b0);
      checks++;
      if (diff !== 32'd4 || bout !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_idle: got diff=%h bout=%b vld=%b, want 4/0/0", diff, bout, out_valid);
      end
   endtask

   task automatic test_small_random;
      logic [G-1:0] x;
      logic [G-1:0] y;
      for (int i = 0; i < 10; i++) begin
         x = G'($urandom_range(15, 10));
         y = G'($urandom_range(9, 5));
         cycle(1'b1, x, y, 1'b1, 1'b0);
         checks++;
         if (diff !== (x - y - 32'd1) || bout !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL small_rand a=%0d b=%0d: got diff=%h bout=%b vld=%b, want %h/0/1",
                     x, y, diff, bout, out_valid, x - y - 32'd1);
         end
      end
   endtask

   task automatic test_wrap;
      cycle(1'b1, 32'd0, 32'd0, 1'b1, 1'b0);
      checks++;
      if (diff !== 32'hFFFF_FFFF || bout !== 1'b1 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL wrap_0_0_1: got diff=%h bout=%b vld=%b, want ffffffff/1/1", diff, bout, out_valid);
      end
      cycle(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      checks++;
      if (diff !== 32'd0 || bout !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL wrap_ff_ff_0: got diff=%h bout=%b vld=%b, want 0/0/1", diff, bout, out_valid);
      end
      cycle(1'b1, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
      checks++;
      if (diff !== 32'd0 || bout !== 1'b1 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL wrap_0_ff_1: got diff=%h bout=%b vld=%b, want 0/1/1", diff, bout, out_valid);
      end
      cycle(1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0);
      checks++;
      if (diff !== 32'hFFFF_FFFF || bout !== 1'b1 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL eq_bin1: got diff=%h bout=%b vld=%b, want ffffffff/1/1", diff, bout, out_valid);
      end
   endtask

   task automatic test_back_to_back;
      cycle(1'b1, 32'd9, 32'd4, 1'b0, 1'b0);
      checks++;
      if (diff !== 32'd5 || bout !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_op1: got diff=%h bout=%b vld=%b, want 5/0/1", diff, bout, out_valid);
      end
      cycle(1'b1, 32'd4, 32'd9, 1'b0, 1'b0);
      checks++;
      if (diff !== 32'hFFFF_FFFB || bout !== 1'b1 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_op2: got diff=%h bout=%b vld=%b, want fffffffb/1/1", diff, bout, out_valid);
      end
      cycle(1'b1, 32'd5, 32'd5, 1'b1, 1'b0);
      checks++;
      if (diff !== 32'hFFFF_FFFF || bout !== 1'b1 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_op3: got diff=%h bout=%b vld=%b, want ffffffff/1/1", diff, bout, out_valid);
      end
      // Same stream, reset asserted together with the third op.
      cycle(1'b1, 32'd9, 32'd4, 1'b0, 1'b0);
      cycle(1'b1, 32'd4, 32'd9, 1'b0, 1'b0);
      checks++;
      if (diff !== 32'hFFFF_FFFB || bout !== 1'b1 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_pre_rst: got diff=%h bout=%b vld=%b, want fffffffb/1/1", diff, bout, out_valid);
      end
      cycle(1'b1, 32'd5, 32'd5, 1'b1, 1'b1);
      checks++;
      if (diff !== 32'd0 || bout !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_mid_rst: got diff=%h bout=%b vld=%b, want 0/0/0", diff, bout, out_valid);
      end
      cycle(1'b0, 32'd5, 32'd5, 1'b1, 1'b0);
      checks++;
      if (diff !== 32'd0 || bout !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_post_rst: got diff=%h bout=%b vld=%b, want 0/0/0", diff, bout, out_valid);
      end
   endtask

`ifdef RCS_OVF_EN
   task automatic test_ovf;
      cycle(1'b1, 32'h8000_0000, 32'd1, 1'b0, 1'b0);
      checks++;
      if (diff !== 32'h7FFF_FFFF || ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set: got diff=%h ovf=%b, want 7fffffff/1", diff, ovf);
      end
      cycle(1'b0, 'x, 'x, 1'bx, 1'b0);
      checks++;
      if (ovf !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL ovf_hold: got ovf=%b vld=%b, want 1/0", ovf, out_valid);
      end
      cycle(1'b1, 32'd5, 32'd3, 1'b0, 1'b0);
      checks++;
      if (diff !== 32'd2 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: got diff=%h ovf=%b, want 2/0", diff, ovf);
      end
      cycle(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      cycle(1'b1, 32'd1, 32'd1, 1'b0, 1'b1);
      checks++;
      if (ovf !== 1'b0 || diff !== 32'd0) begin
         errors++;
         $display("FAIL ovf_reset: got ovf=%b diff=%h, want 0/0", ovf, diff);
      end
   endtask
`endif

   // Randomized stream with random idles, corner operands and occasional
   // resets, compared every cycle against the arithmetic model.
   task automatic test_random_stream;
      logic [G-1:0] x;
      logic [G-1:0] y;
      logic         v;
      logic         r;
      logic         c;
      logic [G-1:0] corners [5];
      corners[0] = 32'h0000_0000;
      corners[1] = 32'hFFFF_FFFF;
      corners[2] = 32'h8000_0000;
      corners[3] = 32'h7FFF_FFFF;
      corners[4] = 32'h0000_0001;
      for (int i = 0; i < 300; i++) begin
         v = ($urandom_range(3, 0) != 0);
         r = ($urandom_range(31, 0) == 0);
         c = 1'($urandom_range(1, 0));
         x = ($urandom_range(3, 0) == 0) ? corners[$urandom_range(4, 0)] : G'($urandom);
         y = ($urandom_range(3, 0) == 0) ? corners[$urandom_range(4, 0)] : G'($urandom);
         if (v) begin
            cycle(1'b1, x, y, c, r);
         end else begin
            cycle(1'b0, 'x, 'x, 1'bx, r);
         end
         checks++;
         if (diff !== m_diff || bout !== m_bout || out_valid !== m_valid) begin
            errors++;
            $display("FAIL rand_stream[%0d]: got diff=%h bout=%b vld=%b, want %h/%b/%b",
                     i, diff, bout, out_valid, m_diff, m_bout, m_valid);
         end
`ifdef RCS_OVF_EN
         checks++;
         if (ovf !== m_ovf) begin
            errors++;
            $display("FAIL rand_ovf[%0d]: got ovf=%b, want %b", i, ovf, m_ovf);
         end
`endif
      end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      bin      = 1'b0;
      m_diff   = '0;
      m_bout   = 1'b0;
      m_valid  = 1'b0;
      m_ovf    = 1'b0;
      test_reset();
      test_basic();
      test_small_random();
      test_wrap();
      test_back_to_back();
`ifdef RCS_OVF_EN
      test_ovf();
`endif
      test_random_stream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
